// File: rtl/usb_rx_pkg.sv
// Shared constants and helpers for the USB receive datapath.
package usb_rx_pkg;

  // Six consecutive decoded ones force the transmitter to insert a zero.
  localparam int USB_STUFF_LIMIT = 6;

  // Data bits per received byte; also sets the bit counter wrap point.
  localparam int USB_BITS_PER_BYTE = 8;

  // Idle line state (J) for a full-speed receiver: D+ high.
  localparam logic USB_IDLE_J = 1'b1;

  // NRZI: no transition between two samples means a 1, a transition means a 0.
  function automatic logic nrzi_decode(input logic cur_bit, input logic prev_bit);
    return (cur_bit == prev_bit);
  endfunction

endpackage

// File: rtl/rx_edge_detect.sv
// Delayed copy of the synchronized D+ line and a one-cycle edge flag.
// The edge flag is high in the cycle where the line differs from its
// previous-cycle value; the receiver uses it to resynchronize its phase.
module rx_edge_detect
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic line_d,
  output logic line_edge
);

  // One-cycle delayed line; idles at J so a quiet line shows no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_d <= USB_IDLE_J;
    end else begin
      line_d <= line;
    end
  end

  assign line_edge = line ^ line_d;

endmodule

// File: rtl/rx_nrzi_unstuff.sv
// USB receive front end: bit-clock recovery by phase counter with edge
// resynchronization, NRZI decode, bit unstuffing and byte framing.
//
// Optional feature: define RX_STUFF_ERR_EN to report a stuff bit decoded
// as 1 on stuff_err. Without it stuff_err is tied low. Stuff bits are
// dropped in both builds.
//
// Output handshake: shift_enable is a one-cycle strobe; d_orig is valid
// exactly while shift_enable is high and holds its last value otherwise.
// byte_received pulses the cycle after the shift_enable that carries the
// eighth bit of a byte. stuff_err pulses in the slot where shift_enable
// would have been for the offending stuff bit. There is no back-pressure.
module rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus_sync,
  input  logic rcving,
  output logic d_orig,
  output logic shift_enable,
  output logic byte_received,
  output logic stuff_err
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] PHASE_MAX = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SMP = PW'(SAMPLE_PT);
  localparam logic [2:0]    ONES_MAX  = 3'(USB_STUFF_LIMIT);
  localparam logic [2:0]    BIT_LAST  = 3'(USB_BITS_PER_BYTE - 1);

  logic          line_d;
  logic          line_edge;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic          sample_evt;
  logic          cur_bit;
  logic          prev_bit;
  logic          pend;
  logic          slot;
  logic          dec_bit;
  logic          is_stuff;
  logic [2:0]    ones;
  logic [2:0]    bit_cnt;
  logic          d_hold;

  rx_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .line      (d_plus_sync),
    .line_d    (line_d),
    .line_edge (line_edge)
  );

  // Sample at a fixed phase of the recovered bit period.
  assign sample_evt = rcving && (phase == PHASE_SMP);

  // Next phase: held at 0 outside a packet, forced to 0 on a line edge,
  // otherwise a free-running modulo-CLKS_PER_BIT counter. The sample is
  // still taken on an edge cycle that coincides with the sample phase,
  // because sample_evt looks at the current phase, not phase_nxt.
  always_comb begin
    phase_nxt = phase;
    if (!rcving) begin
      phase_nxt = '0;
    end else if (line_edge) begin
      phase_nxt = '0;
    end else if (phase == PHASE_MAX) begin
      phase_nxt = '0;
    end else begin
      phase_nxt = phase + 1'b1;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Sampled line history; both idle at J so the first bit of a packet
  // is decoded against the idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_bit  <= USB_IDLE_J;
      prev_bit <= USB_IDLE_J;
    end else if (!rcving) begin
      cur_bit  <= USB_IDLE_J;
      prev_bit <= USB_IDLE_J;
    end else if (sample_evt) begin
      cur_bit  <= d_plus_sync;
      prev_bit <= cur_bit;
    end
  end

  // Marks the cycle right after a sample event: the decode/output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      pend <= sample_evt;
    end
  end

  // The slot only counts while the packet window is still open, so a
  // window that closes right after a sample issues nothing.
  assign slot     = pend && rcving;
  assign dec_bit  = nrzi_decode(cur_bit, prev_bit);
  assign is_stuff = (ones == ONES_MAX);

  assign shift_enable = slot && !is_stuff;
  assign d_orig       = shift_enable ? dec_bit : d_hold;

`ifdef RX_STUFF_ERR_EN
  // A stuff position must carry a 0; a 1 there is a stuffing violation.
  assign stuff_err = slot && is_stuff && dec_bit;
`else
  assign stuff_err = 1'b0;
`endif

  // Holding register so d_orig keeps the last data bit between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_hold <= USB_IDLE_J;
    end else if (shift_enable) begin
      d_hold <= dec_bit;
    end
  end

  // Run length of consecutive decoded ones; a stuff bit restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= '0;
    end else if (!rcving) begin
      ones <= '0;
    end else if (slot) begin
      if (is_stuff) begin
        ones <= '0;
      end else if (dec_bit) begin
        ones <= ones + 3'd1;
      end else begin
        ones <= '0;
      end
    end
  end

  // Bit position within the current byte; advances only on real data bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (!rcving) begin
      bit_cnt <= '0;
    end else if (shift_enable) begin
      if (bit_cnt == BIT_LAST) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Byte strobe one cycle after the last bit of a byte has been shifted.
  // Samples are at least two cycles apart, so it never meets shift_enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_received <= 1'b0;
    end else begin
      byte_received <= shift_enable && (bit_cnt == BIT_LAST);
    end
  end

endmodule

// File: tb/tb_rx_nrzi_unstuff.sv
// Testbench for rx_nrzi_unstuff. Builds packets as data bytes, applies
// USB bit stuffing and NRZI encoding in the bench, drives the line with
// nominal or jittered bit periods, and scores the decoded stream.
// Honors RX_STUFF_ERR_EN for the stuff_err expectation.
module tb_rx_nrzi_unstuff;

  localparam int CPB = 8;
  localparam int SP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d_plus_sync = 1'b1;
  logic rcving = 1'b0;
  logic d_orig;
  logic shift_enable;
  logic byte_received;
  logic stuff_err;

  int checks = 0;
  int fails = 0;

  // Scoreboard state
  logic [0:0] exp_q[$];
  logic       raw_q[$];
  int         run_len;
  int         exp_bytes = 0;
  int         bytes_seen = 0;
  int         exp_stuff = 0;
  int         stuff_seen = 0;
  int         shift_cnt = 0;
  logic       expect_byte = 1'b0;
  logic [0:0] exp_bit;

  rx_nrzi_unstuff #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_PT    (SP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .d_plus_sync   (d_plus_sync),
    .rcving        (rcving),
    .d_orig        (d_orig),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .stuff_err     (stuff_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops expected bits on every shift strobe and tracks byte framing.
  always @(negedge clk) begin
    if (byte_received || expect_byte) check("byte_received_timing", byte_received, expect_byte);
    if (byte_received) bytes_seen++;
    expect_byte = 1'b0;
    if (shift_enable) begin
      check("no_byte_with_shift", byte_received, 0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_shift: got shift_enable=1, expected none (t=%0t)", $time);
      end else begin
        exp_bit = exp_q.pop_front();
        check("d_orig", d_orig, exp_bit);
      end
      shift_cnt++;
      if (shift_cnt % 8 == 0) expect_byte = 1'b1;
    end
    if (stuff_err) begin
      stuff_seen++;
      check("stuff_err_no_shift", shift_enable, 0);
    end
    if (!rcving || rst) shift_cnt = 0;
  end

  // Driver tasks
  task automatic start_pkt();
    raw_q.delete();
    run_len = 0;
  endtask

  // Data byte, LSB first, with a zero stuffed after every six ones.
  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      raw_q.push_back(b[i]);
      if (b[i]) begin
        run_len++;
        if (run_len == 6) begin
          raw_q.push_back(1'b0);
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
    end
    exp_bytes++;
  endtask

  // Raw decoded bit, no stuffing; 'shifted' says whether it must appear.
  task automatic add_raw(input logic b, input logic shifted);
    raw_q.push_back(b);
    if (shifted) exp_q.push_back(b);
  endtask

  // NRZI-encode raw_q onto the line. mode 0: CPB clocks per bit;
  // mode 1: alternating 7/9 clocks per bit.
  task automatic send_pkt(input int mode);
    logic lvl;
    int   per;
    lvl = 1'b1;
    rcving = 1'b1;
    for (int i = 0; i < raw_q.size(); i++) begin
      if (!raw_q[i]) lvl = ~lvl;
      d_plus_sync = lvl;
      per = (mode == 1) ? (((i % 2) == 1) ? 9 : 7) : CPB;
      repeat (per) @(posedge clk);
      #1;
    end
    rcving = 1'b0;
    d_plus_sync = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic end_check(input string name);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_bytes"}, bytes_seen, exp_bytes);
    check({name, "_stuff_errs"}, stuff_seen, exp_stuff);
  endtask

  // Main sequence
  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_d_orig", d_orig, 1);
    check("rst_shift_enable", shift_enable, 0);
    check("rst_byte_received", byte_received, 0);
    check("rst_stuff_err", stuff_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // SYNC pattern KJKJKJKK
    start_pkt();
    add_byte(8'h80);
    send_pkt(0);
    end_check("sync");

    // Stuffed data: SYNC then 0x7F (stuff zero after six ones)
    start_pkt();
    add_byte(8'h80);
    add_byte(8'h7F);
    send_pkt(0);
    end_check("stuffing");

    // Stuff violation: seven decoded ones, then a zero
    start_pkt();
    for (int i = 0; i < 7; i++) add_raw(1'b1, (i < 6));
    add_raw(1'b0, 1'b1);
`ifdef RX_STUFF_ERR_EN
    exp_stuff++;
`endif
    send_pkt(0);
    end_check("violation");

    // Jitter: 7/9 clock bit periods
    start_pkt();
    add_byte(8'h80);
    add_byte(8'($urandom_range(0, 255)));
    add_byte(8'hFF);
    add_byte(8'h3C);
    send_pkt(1);
    end_check("jitter");

    // Abort after five bits, then a full byte from bit 0
    start_pkt();
    add_raw(1'b1, 1'b1);
    add_raw(1'b0, 1'b1);
    add_raw(1'b1, 1'b1);
    add_raw(1'b1, 1'b1);
    add_raw(1'b0, 1'b1);
    send_pkt(0);
    start_pkt();
    add_byte(8'($urandom_range(0, 255)));
    add_byte(8'hA5);
    send_pkt(0);
    end_check("abort");

    // Random packets
    for (int p = 0; p < 8; p++) begin
      int nb;
      start_pkt();
      add_byte(8'h80);
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) add_byte(8'hFF);
        else add_byte(8'($urandom_range(0, 255)));
      end
      send_pkt($urandom_range(0, 1));
    end
    end_check("random");

    // Asynchronous reset mid-cycle while d_orig holds a 0
    start_pkt();
    add_raw(1'b0, 1'b1);
    rcving = 1'b1;
    d_plus_sync = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    check("hold_d_orig", d_orig, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_d_orig", d_orig, 1);
    check("async_rst_shift_enable", shift_enable, 0);
    check("async_rst_byte_received", byte_received, 0);
    check("async_rst_stuff_err", stuff_err, 0);
    rcving = 1'b0;
    d_plus_sync = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("idle_d_orig", d_orig, 1);
    end_check("idle");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
